// File: rtl/srv1_pkg.sv
// Shared definitions for the SRV1 memory stage.
//   - mem_op encoding: bit0 = load, bit1 = store, 2'b00 = no memory access
//   - access size encoding taken from funct3[1:0]
//   - FSM state type used by memory_stage
package srv1_pkg;

    localparam logic [1:0] MEM_NONE      = 2'b00;
    localparam int         MEM_LOAD_BIT  = 0;
    localparam int         MEM_STORE_BIT = 1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/memory_stage_store_adj.sv
// store_adj: combinational store formatter, the mirror image of the load
// adjuster in writeback_stage. Places rs2 into big-endian byte lanes
// (lane [31:24] = byte offset 0) and flags misaligned accesses.
// Ports:
//   data_in    in  32  rs2 value
//   fn3        in   3  funct3; [1:0] selects byte/half/word
//   addr_low   in   2  effective address bits [1:0]
//   wdata      out 32  lane-formatted store data
//   be         out  4  byte enables, be[3] = offset 0
//   misaligned out  1  half on odd address or word not on a 4-byte boundary
module store_adj
    import srv1_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [2:0]  fn3,
    input  logic [1:0]  addr_low,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned
);

    // funct3[2] only distinguishes signed/unsigned loads; it has no effect on stores.
    logic unused_fn3_hi;
    assign unused_fn3_hi = fn3[2];

    always_comb begin
        wdata      = '0;
        be         = '0;
        misaligned = 1'b0;
        case (fn3[1:0])
            SZ_BYTE: begin
                wdata = {4{data_in[7:0]}};
                be    = 4'b1000 >> addr_low;
            end
            SZ_HALF: begin
                // Both halves carry the swapped halfword; be picks the live one.
                wdata      = {2{data_in[7:0], data_in[15:8]}};
                be         = addr_low[1] ? 4'b0011 : 4'b1100;
                misaligned = addr_low[0];
            end
            default: begin
                wdata      = {data_in[7:0], data_in[15:8], data_in[23:16], data_in[31:24]};
                be         = 4'b1111;
                misaligned = (addr_low != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: SRV1 pipeline stage between execute and writeback_stage.
// Issues load/store transactions over a req/ack data bus, stalls execute
// while a transaction is outstanding, and registers the fields consumed by
// writeback_stage. Load data is forwarded raw.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   valid_in, mem_op_in, ctr_word_in, fn3_in, rd_addr_in, alu_in,
//   store_data_in, inc_pc_in, u_type_imm_in      from execute
//   stall_out                       execute must hold its outputs
//   dbus_req/we/addr/wdata/be       data bus request side
//   dbus_rdata, dbus_ack            data bus response side
//   valid_out, ctr_word_out, fn3_out, rd_addr_out, memory_data_out,
//   alu_out, inc_pc_out, u_type_imm_out, fault_out   to writeback_stage
module memory_stage
    import srv1_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [1:0]  mem_op_in,
    input  logic [2:0]  ctr_word_in,
    input  logic [2:0]  fn3_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] store_data_in,
    input  logic [29:0] inc_pc_in,
    input  logic [19:0] u_type_imm_in,
    output logic        stall_out,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [29:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        valid_out,
    output logic [2:0]  ctr_word_out,
    output logic [2:0]  fn3_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] memory_data_out,
    output logic [31:0] alu_out,
    output logic [29:0] inc_pc_out,
    output logic [19:0] u_type_imm_out,
    output logic        fault_out
);

    // Counter holds the number of BUS cycles already spent; the access is
    // aborted at the end of cycle TIMEOUT_CYCLES.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              we_q, we_d;
    logic [29:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;

    // Instruction fields parked while the bus access is outstanding.
    logic [2:0]        h_ctr_q, h_ctr_d;
    logic [2:0]        h_fn3_q, h_fn3_d;
    logic [4:0]        h_rd_q, h_rd_d;
    logic [31:0]       h_alu_q, h_alu_d;
    logic [29:0]       h_pc_q, h_pc_d;
    logic [19:0]       h_imm_q, h_imm_d;

    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic [2:0]        ctr_q, ctr_d;
    logic [2:0]        fn3_q, fn3_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       mem_q, mem_d;
    logic [31:0]       alu_q, alu_d;
    logic [29:0]       pc_q, pc_d;
    logic [19:0]       imm_q, imm_d;

    logic [31:0]       adj_wdata;
    logic [3:0]        adj_be;
    logic              adj_misaligned;

    store_adj u_store_adj (
        .data_in    (store_data_in),
        .fn3        (fn3_in),
        .addr_low   (alu_in[1:0]),
        .wdata      (adj_wdata),
        .be         (adj_be),
        .misaligned (adj_misaligned)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        h_ctr_d = h_ctr_q;
        h_fn3_d = h_fn3_q;
        h_rd_d  = h_rd_q;
        h_alu_d = h_alu_q;
        h_pc_d  = h_pc_q;
        h_imm_d = h_imm_q;
        valid_d = valid_q;
        fault_d = fault_q;
        ctr_d   = ctr_q;
        fn3_d   = fn3_q;
        rd_d    = rd_q;
        mem_d   = mem_q;
        alu_d   = alu_q;
        pc_d    = pc_q;
        imm_d   = imm_q;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                fault_d = 1'b0;
                if (valid_in) begin
                    if (mem_op_in == MEM_NONE || adj_misaligned) begin
                        // Pass straight through; a misaligned access never
                        // reaches the bus and must not write the regfile.
                        valid_d = 1'b1;
                        fault_d = (mem_op_in != MEM_NONE);
                        ctr_d   = {ctr_word_in[2:1], ctr_word_in[0] & (mem_op_in == MEM_NONE)};
                        fn3_d   = fn3_in;
                        rd_d    = rd_addr_in;
                        mem_d   = '0;
                        alu_d   = alu_in;
                        pc_d    = inc_pc_in;
                        imm_d   = u_type_imm_in;
                    end else begin
                        // mem_op 2'b11 falls here with bit1 set and acts as a store.
                        we_d    = mem_op_in[MEM_STORE_BIT];
                        addr_d  = alu_in[31:2];
                        wdata_d = mem_op_in[MEM_STORE_BIT] ? adj_wdata : '0;
                        be_d    = mem_op_in[MEM_STORE_BIT] ? adj_be : 4'b1111;
                        h_ctr_d = ctr_word_in;
                        h_fn3_d = fn3_in;
                        h_rd_d  = rd_addr_in;
                        h_alu_d = alu_in;
                        h_pc_d  = inc_pc_in;
                        h_imm_d = u_type_imm_in;
                        cnt_d   = '0;
                        state_d = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                valid_d = 1'b0;
                fault_d = 1'b0;
                fn3_d   = h_fn3_q;
                rd_d    = h_rd_q;
                alu_d   = h_alu_q;
                pc_d    = h_pc_q;
                imm_d   = h_imm_q;
                // Ack is tested first so it wins over a simultaneous expiry.
                if (dbus_ack) begin
                    valid_d = 1'b1;
                    ctr_d   = h_ctr_q;
                    mem_d   = we_q ? '0 : dbus_rdata;
                    state_d = ST_IDLE;
                end else if (TIMEOUT_CYCLES > 0 && cnt_q == CNT_LAST) begin
                    valid_d = 1'b1;
                    fault_d = 1'b1;
                    ctr_d   = {h_ctr_q[2:1], 1'b0};
                    mem_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            h_ctr_q <= '0;
            h_fn3_q <= '0;
            h_rd_q  <= '0;
            h_alu_q <= '0;
            h_pc_q  <= '0;
            h_imm_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            ctr_q   <= '0;
            fn3_q   <= '0;
            rd_q    <= '0;
            mem_q   <= '0;
            alu_q   <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            h_ctr_q <= h_ctr_d;
            h_fn3_q <= h_fn3_d;
            h_rd_q  <= h_rd_d;
            h_alu_q <= h_alu_d;
            h_pc_q  <= h_pc_d;
            h_imm_q <= h_imm_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            ctr_q   <= ctr_d;
            fn3_q   <= fn3_d;
            rd_q    <= rd_d;
            mem_q   <= mem_d;
            alu_q   <= alu_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
        end
    end

    // Request and stall decode straight from the state flop, so reset drops
    // them on the same edge.
    assign dbus_req        = (state_q == ST_BUS);
    assign stall_out       = (state_q == ST_BUS);
    assign dbus_we         = we_q;
    assign dbus_addr       = addr_q;
    assign dbus_wdata      = wdata_q;
    assign dbus_be         = be_q;

    assign valid_out       = valid_q;
    assign fault_out       = fault_q;
    assign ctr_word_out    = ctr_q;
    assign fn3_out         = fn3_q;
    assign rd_addr_out     = rd_q;
    assign memory_data_out = mem_q;
    assign alu_out         = alu_q;
    assign inc_pc_out      = pc_q;
    assign u_type_imm_out  = imm_q;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [1:0]  mem_op_in;
    logic [2:0]  ctr_word_in;
    logic [2:0]  fn3_in;
    logic [4:0]  rd_addr_in;
    logic [31:0] alu_in;
    logic [31:0] store_data_in;
    logic [29:0] inc_pc_in;
    logic [19:0] u_type_imm_in;
    logic        stall_out;
    logic        dbus_req;
    logic        dbus_we;
    logic [29:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        valid_out;
    logic [2:0]  ctr_word_out;
    logic [2:0]  fn3_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] memory_data_out;
    logic [31:0] alu_out;
    logic [29:0] inc_pc_out;
    logic [19:0] u_type_imm_out;
    logic        fault_out;

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_op_in(mem_op_in),
        .ctr_word_in(ctr_word_in), .fn3_in(fn3_in), .rd_addr_in(rd_addr_in),
        .alu_in(alu_in), .store_data_in(store_data_in), .inc_pc_in(inc_pc_in),
        .u_type_imm_in(u_type_imm_in), .stall_out(stall_out), .dbus_req(dbus_req),
        .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_be(dbus_be), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
        .valid_out(valid_out), .ctr_word_out(ctr_word_out), .fn3_out(fn3_out),
        .rd_addr_out(rd_addr_out), .memory_data_out(memory_data_out),
        .alu_out(alu_out), .inc_pc_out(inc_pc_out), .u_type_imm_out(u_type_imm_out),
        .fault_out(fault_out)
    );

    typedef struct {
        logic [2:0]  ctr;
        logic [2:0]  fn3;
        logic [4:0]  rd;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [29:0] pc;
        logic [19:0] imm;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference store formatting: byte i of rs2 lands at address offset+i,
    // and address offset k lives in lane [31-8k -: 8] with enable bit 3-k.
    function automatic void model_store(input logic [31:0] rs2, input logic [1:0] sz,
                                        input logic [1:0] off,
                                        output logic [31:0] wd, output logic [3:0] be);
        int nb;
        int k;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        wd = '0;
        be = '0;
        for (int i = 0; i < nb; i++) begin
            k = int'(off) + i;
            wd[31-8*k -: 8] = rs2[8*i +: 8];
            be[3-k] = 1'b1;
        end
    endfunction

    // Monitor: every presented output must match the oldest expectation.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_valid: got valid_out=1 alu_out=%0h, expected no output", alu_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("ctr_word_out",    ctr_word_out,    mon_e.ctr);
                check("fn3_out",         fn3_out,         mon_e.fn3);
                check("rd_addr_out",     rd_addr_out,     mon_e.rd);
                check("memory_data_out", memory_data_out, mon_e.mem);
                check("alu_out",         alu_out,         mon_e.alu);
                check("inc_pc_out",      inc_pc_out,      mon_e.pc);
                check("u_type_imm_out",  u_type_imm_out,  mon_e.imm);
                check("fault_out",       fault_out,       mon_e.fault);
            end
        end
    end

    // Issue one instruction; lat = BUS cycles until ack (1 = immediate ack),
    // lat > TO means the bus never answers.
    task automatic issue(input logic [1:0] op, input logic [2:0] fn3, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [2:0] ctr, input logic [4:0] rd,
                         input logic [29:0] pc, input logic [19:0] imm, input int lat,
                         input logic [31:0] rdata);
        exp_t        e;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] msk;
        int          nb;
        logic        mis;
        logic        st;
        nb  = (fn3[1:0] == 2'd0) ? 1 : (fn3[1:0] == 2'd1) ? 2 : 4;
        mis = (int'(alu[1:0]) % nb) != 0;
        e.ctr = ctr; e.fn3 = fn3; e.rd = rd; e.mem = '0; e.alu = alu;
        e.pc = pc; e.imm = imm; e.fault = 1'b0;
        valid_in = 1'b1; mem_op_in = op; fn3_in = fn3; alu_in = alu; store_data_in = rs2;
        ctr_word_in = ctr; rd_addr_in = rd; inc_pc_in = pc; u_type_imm_in = imm;
        if (op == 2'b00 || mis) begin
            if (op != 2'b00) begin
                e.fault  = 1'b1;
                e.ctr[0] = 1'b0;
            end
            exp_q.push_back(e);
            @(posedge clk); #1;
            valid_in = 1'b0;
            check("no_req", dbus_req, 1'b0);
            check("no_stall", stall_out, 1'b0);
        end else begin
            st = op[1];
            model_store(rs2, fn3[1:0], alu[1:0], wd, be);
            if (!st) be = 4'b1111;
            msk = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            @(posedge clk); #1;
            // Execute keeps presenting something while stalled; it must be ignored.
            valid_in = 1'b1; mem_op_in = 2'($urandom); alu_in = $urandom;
            fn3_in = 3'($urandom); store_data_in = $urandom;
            for (int c = 1; c <= int'(TO); c++) begin
                check("req", dbus_req, 1'b1);
                check("stall", stall_out, 1'b1);
                check("dbus_addr", dbus_addr, alu[31:2]);
                check("dbus_we", dbus_we, st);
                check("dbus_be", dbus_be, be);
                if (st) check("dbus_wdata", dbus_wdata & msk, wd);
                if (c == lat) begin
                    dbus_ack = 1'b1;
                    dbus_rdata = rdata;
                    e.mem = st ? 32'h0 : rdata;
                    exp_q.push_back(e);
                    @(posedge clk); #1;
                    dbus_ack = 1'b0;
                    dbus_rdata = $urandom;
                    break;
                end
                if (c == int'(TO)) begin
                    e.fault  = 1'b1;
                    e.ctr[0] = 1'b0;
                    exp_q.push_back(e);
                end
                @(posedge clk); #1;
            end
            valid_in = 1'b0;
            check("req_drop", dbus_req, 1'b0);
            check("stall_drop", stall_out, 1'b0);
        end
    endtask

    task automatic idle_cycle(input logic stray_ack);
        valid_in = 1'b0;
        dbus_ack = stray_ack;
        dbus_rdata = $urandom;
        @(posedge clk); #1;
        dbus_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; mem_op_in = '0; ctr_word_in = '0; fn3_in = '0;
        rd_addr_in = '0; alu_in = '0; store_data_in = '0; inc_pc_in = '0;
        u_type_imm_in = '0; dbus_rdata = '0; dbus_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_stall", stall_out, 1'b0);
        check("rst_req", dbus_req, 1'b0);
        check("rst_we", dbus_we, 1'b0);
        check("rst_be", dbus_be, 4'b0);
        check("rst_fault", fault_out, 1'b0);
        check("rst_mem", memory_data_out, 32'h0);
        check("rst_alu", alu_out, 32'h0);
        check("rst_ctr", ctr_word_out, 3'h0);
        check("rst_addr", dbus_addr, 30'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        issue(2'b00, 3'b000, 32'h0000_1234, 32'h0, 3'b011, 5'd1, 30'h10, 20'h1, 1, 32'h0);
        issue(2'b10, 3'b010, 32'h0000_0100, 32'hAABBCCDD, 3'b000, 5'd0, 30'h11, 20'h2, 3, 32'h0);
        issue(2'b10, 3'b001, 32'h0000_0102, 32'h0000BEEF, 3'b000, 5'd0, 30'h12, 20'h3, 1, 32'h0);
        issue(2'b10, 3'b000, 32'h0000_0101, 32'h0000_0055, 3'b000, 5'd0, 30'h13, 20'h4, 2, 32'h0);
        issue(2'b01, 3'b010, 32'h0000_0200, 32'h0, 3'b101, 5'd7, 30'h14, 20'h5, 1, 32'h11223344);
        issue(2'b01, 3'b001, 32'h0000_0203, 32'h0, 3'b101, 5'd8, 30'h15, 20'h6, 1, 32'h0);
        issue(2'b10, 3'b010, 32'h0000_0300, 32'h12345678, 3'b011, 5'd9, 30'h16, 20'h7, TO + 5, 32'h0);
        issue(2'b01, 3'b010, 32'h0000_0304, 32'h0, 3'b011, 5'd10, 30'h17, 20'h8, TO, 32'hCAFEF00D);
        issue(2'b11, 3'b000, 32'h0000_0403, 32'h0000_00A5, 3'b001, 5'd11, 30'h18, 20'h9, 2, 32'hFFFF_FFFF);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Reset while a load is outstanding: transaction abandoned, stray ack ignored
        valid_in = 1'b1; mem_op_in = 2'b01; fn3_in = 3'b010; alu_in = 32'h0000_0500;
        ctr_word_in = 3'b001; rd_addr_in = 5'd3;
        @(posedge clk); #1;
        valid_in = 1'b0;
        check("midbus_req", dbus_req, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstbus_req", dbus_req, 1'b0);
        check("rstbus_stall", stall_out, 1'b0);
        check("rstbus_valid", valid_out, 1'b0);
        rst_n = 1'b1;
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        check("stray_ack_valid", valid_out, 1'b0);

        // Randomised traffic
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
            issue(2'($urandom_range(0, 3)), 3'($urandom), $urandom, $urandom,
                  3'($urandom), 5'($urandom), 30'($urandom), 20'($urandom),
                  int'($urandom_range(1, TO + 2)), $urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
